rr_output_arbiter: RTL and testbench
====================================

RR_OUTPUT_ARBITER -- requirements
Module: rr_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 4, SHALL set the number of competing input ports (2..16).
REQ-002 Parameter ADDR_W, default 3, SHALL set the width of each next-hop address.
REQ-003 Parameter OUT_ADDR, default 3'd3, SHALL set the next-hop code that this output port serves.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 nexthop_addr_i  input  NUM_IN*ADDR_W  SHALL carry the packed per-input next-hop addresses; input k occupies bits [k*ADDR_W +: ADDR_W].
REQ-007 req_valid_i  input  NUM_IN  SHALL mark that input k holds a valid flit.
REQ-008 req_tail_i  input  NUM_IN  SHALL mark that input k's current flit is a tail.
REQ-009 out_ready_i  input  1  SHALL indicate that the downstream crossbar/link accepts a flit this cycle.
REQ-010 grant_o  output  NUM_IN  SHALL be the one-hot grant, registered.
REQ-011 grant_sel_o  output  $clog2(NUM_IN)  SHALL be the binary index of the granted input, for crossbar select, registered.
REQ-012 grant_valid_o  output  1  SHALL be high whenever grant_o is non-zero.
REQ-013 xfer_o  output  1  SHALL pulse high combinationally in any cycle where a flit transfers (grant_valid_o & req_valid_i[grant_sel_o] & out_ready_i).

Function
REQ-014 Input k SHALL be requesting iff req_valid_i[k] is high and nexthop_addr_i of input k equals OUT_ADDR.
REQ-015 The FSM SHALL have two states, IDLE and BUSY.
REQ-016 In IDLE with at least one requester, the winner SHALL be the first requester found by searching upward from pointer ptr, wrapping at NUM_IN-1 to 0; grant SHALL register on the next edge (1-cycle latency), and the state SHALL become BUSY.
REQ-017 On each grant to input k, ptr SHALL update to (k+1) mod NUM_IN, so that the winner becomes lowest priority.
REQ-018 In IDLE with no requester, outputs SHALL stay zero and ptr SHALL be unchanged.
REQ-019 In BUSY, grant_o and grant_sel_o SHALL hold constant until the release condition; a change of other inputs' requests SHALL NOT affect them.
REQ-020 Release SHALL occur on a cycle with xfer_o high and req_tail_i[grant_sel_o] high; on the next edge the state SHALL go to IDLE and all grant outputs SHALL clear.
REQ-021 Re-arbitration SHALL begin in the IDLE cycle after release; there is no same-cycle regrant, so each packet costs at least one idle bubble.
REQ-022 If the granted input deasserts req_valid_i, or out_ready_i is low, the grant SHALL hold with no transfer (stall).
REQ-023 A head flit whose address differs from OUT_ADDR on a granted input mid-packet SHALL be ignored; packet ownership depends only on the grant.

Reset
REQ-024 Asserting reset at any time, including mid-packet, SHALL immediately force state=IDLE, ptr=0, grant_o=0, grant_sel_o=0, and grant_valid_o=0.
REQ-025 After reset deasserts, the first arbitration SHALL favour input 0, then 1, and so on.

Configuration
REQ-026 Macro RR_ARB_PKT_HOLD_EN: when defined, the behaviour of REQ-019..REQ-022 (wormhole hold until tail) SHALL apply.
REQ-027 When RR_ARB_PKT_HOLD_EN is undefined, every transferred flit SHALL be treated as a tail; req_tail_i SHALL be ignored, and the grant releases after each single-flit transfer (per-flit arbitration).

Verification (NUM_IN=4, ADDR_W=3, OUT_ADDR=3, HOLD_EN defined unless stated)
REQ-028 Reset, then assert inputs 0..3 all valid with address 3 and every flit a tail, with out_ready_i=1. Grant order SHALL be 0,1,2,3,0 on cycles 1,3,5,7,9.
REQ-029 Input 2 valid with address 3 and input 1 valid with address 5. Only input 2 SHALL be granted (grant_o=4'b0100, grant_sel_o=2), and input 1 SHALL never be granted.
REQ-030 Input 1 sends a 4-flit packet (tail on flit 4) while input 3 requests throughout. grant_o SHALL stay 4'b0010 for 4 transfers; input 3 SHALL be granted 2 cycles after the tail transfer.
REQ-031 With input 0 granted, hold out_ready_i=0 for 3 cycles. xfer_o SHALL stay 0 and the grant SHALL be unchanged; transfers SHALL resume when ready returns.
REQ-032 Assert reset asynchronously while input 2 is mid-packet. Grant outputs SHALL go to 0 without a clock edge; the next arbitration with inputs 2 and 3 requesting SHALL grant input 2 (ptr=0).
REQ-033 With HOLD_EN undefined, inputs 0 and 1 send non-tail flits continuously. Grants SHALL alternate 0,1,0,1 per flit.

Source files
------------

// File: rtl/rr_output_arbiter.sv
// -----------------------------------------------------------------------------
// rr_output_arbiter
//
// Round-robin arbiter for one router output port. Several input ports compete
// for this output. An input competes only when it holds a valid flit whose
// next-hop address matches OUT_ADDR. The winner holds the output until its
// packet releases it. Grants are registered, so a grant appears one cycle
// after arbitration. There is always at least one idle cycle between two
// consecutive grants.
//
// Configuration macro:
//   RR_ARB_PKT_HOLD_EN  defined   : wormhole hold. The grant is kept until the
//                                   tail flit of the packet transfers.
//                       undefined : per-flit arbitration. Every transferred
//                                   flit releases the grant, and req_tail_i is
//                                   ignored.
//
// Parameters:
//   NUM_IN    number of competing input ports (2..16)
//   ADDR_W    width of each next-hop address
//   OUT_ADDR  next-hop code served by this output port
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   nexthop_addr_i packed per-input next-hop address; input k at [k*ADDR_W +: ADDR_W]
//   req_valid_i    per-input valid flit
//   req_tail_i     per-input tail marker for the current flit
//   out_ready_i    downstream accepts a flit this cycle
//   grant_o        registered one-hot grant
//   grant_sel_o    registered binary index of the granted input (crossbar select)
//   grant_valid_o  registered, high whenever grant_o is non-zero
//   xfer_o         combinational transfer strobe for the current cycle
// -----------------------------------------------------------------------------
module rr_output_arbiter #(
    parameter int                NUM_IN   = 4,
    parameter int                ADDR_W   = 3,
    parameter logic [ADDR_W-1:0] OUT_ADDR = 3'd3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN*ADDR_W-1:0]    nexthop_addr_i,
    input  logic [NUM_IN-1:0]           req_valid_i,
    input  logic [NUM_IN-1:0]           req_tail_i,
    input  logic                        out_ready_i,
    output logic [NUM_IN-1:0]           grant_o,
    output logic [$clog2(NUM_IN)-1:0]   grant_sel_o,
    output logic                        grant_valid_o,
    output logic                        xfer_o
);

    localparam int SEL_W = $clog2(NUM_IN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    logic [SEL_W-1:0]  ptr;          // highest-priority input for the next arbitration
    logic [NUM_IN-1:0] req_vec;      // inputs actually competing for this output
    logic              any_req;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  next_ptr;
    logic              release_pkt;
    int                idx;

    // An input competes only if its flit is headed to this output.
    // NOTE: every signal assigned in always_comb gets a default before any
    // conditional logic. Without it, a path that skips the assignment would
    // infer a latch.
    always_comb begin
        req_vec = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            req_vec[k] = req_valid_i[k] &&
                         (nexthop_addr_i[k*ADDR_W +: ADDR_W] == OUT_ADDR);
        end
    end

    // Search upward from ptr and wrap at NUM_IN-1. The first hit wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!any_req && req_vec[idx[SEL_W-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[SEL_W-1:0];
            end
        end
    end

    // After a grant, the winner becomes the lowest-priority input.
    assign next_ptr = (winner == SEL_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;

    // A flit moves only when the owner presents data and downstream accepts it.
    assign xfer_o = grant_valid_o & req_valid_i[grant_sel_o] & out_ready_i;

`ifdef RR_ARB_PKT_HOLD_EN
    // The owner keeps the output until its tail flit transfers.
    assign release_pkt = xfer_o & req_tail_i[grant_sel_o];
`else
    // Every transferred flit counts as a tail, so the tail markers are not used.
    logic unused_tail;
    assign unused_tail = ^req_tail_i;
    assign release_pkt = xfer_o;
`endif

    // While BUSY, only the owner's transfers matter. The other inputs'
    // requests and the owner's address do not affect the grant.
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_o       <= '0;
            grant_sel_o   <= '0;
            grant_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state         <= BUSY;
                        grant_o       <= NUM_IN'(1) << winner;
                        grant_sel_o   <= winner;
                        grant_valid_o <= 1'b1;
                        ptr           <= next_ptr;
                    end
                end
                BUSY: begin
                    // There is no same-cycle regrant. Arbitration resumes in
                    // the IDLE cycle that follows.
                    if (release_pkt) begin
                        state         <= IDLE;
                        grant_o       <= '0;
                        grant_sel_o   <= '0;
                        grant_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_output_arbiter
//
// Directed bench for rr_output_arbiter with NUM_IN=4, ADDR_W=3, OUT_ADDR=3.
// Each cycle, the expected grant and transfer strobe are pushed to a
// scoreboard queue when the stimulus is driven. They are popped and compared
// when the outputs are sampled at the falling edge. Expectations that depend
// on the packet-hold mode follow RR_ARB_PKT_HOLD_EN.
// -----------------------------------------------------------------------------
module tb_rr_output_arbiter;

    localparam int NUM_IN = 4;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       gv;
        logic       xfer;
    } exp_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_IN*ADDR_W-1:0] nexthop_addr;
    logic [NUM_IN-1:0]        req_valid;
    logic [NUM_IN-1:0]        req_tail;
    logic                     out_ready;
    logic [NUM_IN-1:0]        grant;
    logic [1:0]               grant_sel;
    logic                     grant_valid;
    logic                     xfer;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    rr_output_arbiter #(
        .NUM_IN   (NUM_IN),
        .ADDR_W   (ADDR_W),
        .OUT_ADDR (3'd3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .nexthop_addr_i (nexthop_addr),
        .req_valid_i    (req_valid),
        .req_tail_i     (req_tail),
        .out_ready_i    (out_ready),
        .grant_o        (grant),
        .grant_sel_o    (grant_sel),
        .grant_valid_o  (grant_valid),
        .xfer_o         (xfer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [3:0] onehot(int k);
        logic [3:0] v;
        v = 4'b0001 << k;
        return v;
    endfunction

    function automatic logic [1:0] encode(logic [3:0] g);
        logic [1:0] s;
        s = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) s = 2'(i);
        end
        return s;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(logic [3:0] g, logic x);
        exp_t e;
        e.grant = g;
        e.sel   = encode(g);
        e.gv    = |g;
        e.xfer  = x;
        sb.push_back(e);
    endtask

    task automatic compare_head(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "/grant"},       8'(grant),       8'(e.grant));
            chk({tag, "/grant_sel"},   8'(grant_sel),   8'(e.sel));
            chk({tag, "/grant_valid"}, 8'(grant_valid), 8'(e.gv));
            chk({tag, "/xfer"},        8'(xfer),        8'(e.xfer));
        end
    endtask

    // Check outputs right now, without waiting for a clock edge.
    task automatic sample_now(string tag, logic [3:0] g, logic x);
        push_exp(g, x);
        compare_head(tag);
    endtask

    // One cycle: expectation for the current cycle, sample at negedge,
    // then return just after the next rising edge for the next stimulus.
    task automatic cyc(string tag, logic [3:0] g, logic x);
        push_exp(g, x);
        @(negedge clk);
        compare_head(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(int k, logic [2:0] a);
        nexthop_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic do_reset();
        req_valid    = '0;
        req_tail     = '0;
        out_ready    = 1'b0;
        nexthop_addr = '0;
        reset        = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        sample_now("reset_state", 4'b0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_tail     = '0;
        out_ready    = 1'b0;
        nexthop_addr = '0;

        // Round-robin order with every input competing and single-flit packets.
        do_reset();
        for (int k = 0; k < 4; k++) set_addr(k, 3'd3);
        req_valid = 4'b1111;
        req_tail  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 1) cyc("rr_order", onehot(((c - 1) / 2) % 4), 1'b1);
            else            cyc("rr_order_bubble", 4'b0000, 1'b0);
        end

        // An input addressed elsewhere never competes.
        do_reset();
        set_addr(2, 3'd3);
        set_addr(1, 3'd5);
        req_valid = 4'b0110;
        req_tail  = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 1) cyc("addr_filter", 4'b0100, 1'b1);
            else            cyc("addr_filter_bubble", 4'b0000, 1'b0);
        end

        // Multi-flit packet on input 1 while input 3 keeps requesting.
        do_reset();
        for (int k = 0; k < 4; k++) set_addr(k, 3'd3);
        req_valid = 4'b1010;
        req_tail  = 4'b1000;
        out_ready = 1'b1;
        cyc("pkt_c0", 4'b0000, 1'b0);
`ifdef RR_ARB_PKT_HOLD_EN
        cyc("pkt_f1", 4'b0010, 1'b1);
        set_addr(1, 3'd5);            // a mid-packet address change is ignored
        cyc("pkt_f2", 4'b0010, 1'b1);
        cyc("pkt_f3", 4'b0010, 1'b1);
        req_tail[1] = 1'b1;
        cyc("pkt_tail", 4'b0010, 1'b1);
        req_tail[1] = 1'b0;
        cyc("pkt_bubble", 4'b0000, 1'b0);
        cyc("pkt_next", 4'b1000, 1'b1);
`else
        cyc("flit_1", 4'b0010, 1'b1);
        cyc("flit_b1", 4'b0000, 1'b0);
        cyc("flit_3", 4'b1000, 1'b1);
        cyc("flit_b2", 4'b0000, 1'b0);
        cyc("flit_1b", 4'b0010, 1'b1);
`endif

        // Stall on ready low, then on owner valid low; grant must hold.
        do_reset();
        set_addr(0, 3'd3);
        req_valid = 4'b0001;
        req_tail  = 4'b1111;
        out_ready = 1'b1;
        cyc("stall_c0", 4'b0000, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) cyc("stall_ready", 4'b0001, 1'b0);
        out_ready = 1'b1;
        req_valid = 4'b0000;
        cyc("stall_novalid", 4'b0001, 1'b0);
        req_valid = 4'b0001;
        cyc("stall_resume", 4'b0001, 1'b1);
        req_valid = 4'b0000;
        cyc("stall_release", 4'b0000, 1'b0);
        cyc("idle_no_req", 4'b0000, 1'b0);

        // Asynchronous reset while input 2 owns the output.
        do_reset();
        set_addr(2, 3'd3);
        set_addr(3, 3'd3);
        req_valid = 4'b0100;
        req_tail  = 4'b0000;
        out_ready = 1'b1;
        cyc("areset_c0", 4'b0000, 1'b0);
        out_ready = 1'b0;
        cyc("areset_own1", 4'b0100, 1'b0);
        cyc("areset_own2", 4'b0100, 1'b0);
        #2;
        reset = 1'b1;                 // between clock edges
        #1;
        sample_now("async_reset", 4'b0000, 1'b0);
        req_valid = 4'b1100;
        req_tail  = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc("areset_regrant2", 4'b0100, 1'b1);
        cyc("areset_bubble", 4'b0000, 1'b0);
        cyc("areset_grant3", 4'b1000, 1'b1);

        // Inputs 0 and 1 stream non-tail flits.
        do_reset();
        set_addr(0, 3'd3);
        set_addr(1, 3'd3);
        req_valid = 4'b0011;
        req_tail  = 4'b0000;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
`ifdef RR_ARB_PKT_HOLD_EN
            if (c >= 1) cyc("stream_hold", 4'b0001, 1'b1);
            else        cyc("stream_c0", 4'b0000, 1'b0);
`else
            if (c % 2 == 1) cyc("stream_alt", onehot(((c - 1) / 2) % 2), 1'b1);
            else            cyc("stream_bubble", 4'b0000, 1'b0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
